// File: rtl/reel_stop_seq.sv
// Slot-style reel stopper: one 16-bit Galois LFSR per reel, frozen one reel at a time while
// stop_req_i is held. Optional REEL_SEED_LOAD_EN adds seed_load_i/seed_val_i for idle reseeding.
module reel_stop_seq #(
  parameter int unsigned NUM_REELS = 4,
  parameter int unsigned NUM_W     = 4,
  parameter int unsigned DWELL     = 10,
  parameter int unsigned CNT_W     = 27,
  parameter logic [15:0] SEED_BASE = 16'hACE1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         stop_req_i,
`ifdef REEL_SEED_LOAD_EN
  input  logic                         seed_load_i,
  input  logic [15:0]                  seed_val_i,
`endif
  output logic [NUM_REELS*NUM_W-1:0]   rand_nums_o,
  output logic [NUM_REELS-1:0]         frozen_o,
  output logic [NUM_REELS-1:0]         reel_stop_pulse_o,
  output logic                         done_o,
  output logic                         busy_o
);

  localparam int unsigned IdxW = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NUM_REELS - 1);
  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StSpin, StDone} state_e;

  function automatic logic [15:0] galois(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Per-reel seed spreading; an all-zero LFSR would lock up, so zero maps to 1.
  function automatic logic [15:0] seed_of(input logic [15:0] base, input int unsigned k);
    logic [15:0] s;
    s = base ^ 16'(k * 32'h1F35);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [NUM_REELS-1:0]   frozen_q, frozen_d;
  logic [NUM_REELS-1:0]   pulse_q, pulse_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [15:0]            lfsr_q [NUM_REELS];
  logic [15:0]            lfsr_d [NUM_REELS];
  logic                   load_seed;
  logic [15:0]            seed_src;

`ifdef REEL_SEED_LOAD_EN
  assign load_seed = seed_load_i && (state_q == StIdle);
  assign seed_src  = seed_val_i;
`else
  assign load_seed = 1'b0;
  assign seed_src  = SEED_BASE;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    frozen_d = frozen_q;
    pulse_d  = '0;
    done_d   = done_q;
    busy_d   = busy_q;
    case (state_q)
      StIdle: begin
        frozen_d = '0;
        cnt_d    = '0;
        idx_d    = '0;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        if (stop_req_i) begin
          state_d = StSpin;
          busy_d  = 1'b1;
        end
      end
      StSpin: begin
        // Abort has priority over a freeze landing on the same edge.
        if (!stop_req_i) begin
          state_d  = StIdle;
          frozen_d = '0;
          cnt_d    = '0;
          idx_d    = '0;
          done_d   = 1'b0;
          busy_d   = 1'b0;
        end else if (cnt_q == DwellLast) begin
          frozen_d[idx_q] = 1'b1;
          pulse_d[idx_q]  = 1'b1;
          cnt_d           = '0;
          if (idx_q == LastIdx) begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        if (!stop_req_i) begin
          state_d  = StIdle;
          frozen_d = '0;
          cnt_d    = '0;
          idx_d    = '0;
          done_d   = 1'b0;
          busy_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_REELS; k++) begin
      lfsr_d[k] = lfsr_q[k];
      if (load_seed) begin
        lfsr_d[k] = seed_of(seed_src, k);
      end else if (!frozen_q[k]) begin
        lfsr_d[k] = galois(lfsr_q[k]);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      frozen_q <= '0;
      pulse_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int unsigned k = 0; k < NUM_REELS; k++) begin
        lfsr_q[k] <= seed_of(SEED_BASE, k);
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frozen_q <= frozen_d;
      pulse_q  <= pulse_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      for (int unsigned k = 0; k < NUM_REELS; k++) begin
        lfsr_q[k] <= lfsr_d[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_REELS; k++) begin : g_out
    assign rand_nums_o[k*NUM_W +: NUM_W] = lfsr_q[k][NUM_W-1:0];
  end

  assign frozen_o          = frozen_q;
  assign reel_stop_pulse_o = pulse_q;
  assign done_o            = done_q;
  assign busy_o            = busy_q;

endmodule

// File: tb/tb_reel_stop_seq.sv
// Bench for reel_stop_seq: default instance and an 8-reel/3-bit/dwell-1 instance, both checked
// against an elapsed-edge reference model under directed and random stop_req stimulus.
module tb_reel_stop_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        stop_req;
  logic        seed_load;
  logic [15:0] seed_val;

  logic [15:0] rn0;
  logic [3:0]  fr0, pu0;
  logic        dn0, bs0;
  logic [23:0] rn1;
  logic [7:0]  fr1, pu1;
  logic        dn1, bs1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reel_stop_seq u_dut0 (
    .clk_i             (clk),
    .reset_i           (reset),
    .stop_req_i        (stop_req),
`ifdef REEL_SEED_LOAD_EN
    .seed_load_i       (seed_load),
    .seed_val_i        (seed_val),
`endif
    .rand_nums_o       (rn0),
    .frozen_o          (fr0),
    .reel_stop_pulse_o (pu0),
    .done_o            (dn0),
    .busy_o            (bs0)
  );

  reel_stop_seq #(
    .NUM_REELS (8),
    .NUM_W     (3),
    .DWELL     (1)
  ) u_dut1 (
    .clk_i             (clk),
    .reset_i           (reset),
    .stop_req_i        (stop_req),
`ifdef REEL_SEED_LOAD_EN
    .seed_load_i       (seed_load),
    .seed_val_i        (seed_val),
`endif
    .rand_nums_o       (rn1),
    .frozen_o          (fr1),
    .reel_stop_pulse_o (pu1),
    .done_o            (dn1),
    .busy_o            (bs1)
  );

  // Reference model: a sequence is "active" from the first sampled high stop_req; m_n counts
  // edges since then. Reel k is frozen once m_n >= (k+1)*DWELL.
  int          nr [2] = '{4, 8};
  int          nw [2] = '{4, 3};
  int          dw [2] = '{10, 1};
  logic [15:0] m_lfsr [2][8];
  bit          m_active [2];
  int          m_n [2];

  function automatic logic [15:0] m_galois(input logic [15:0] s);
    logic [15:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  function automatic logic [15:0] m_seed(input logic [15:0] b, input int k);
    logic [15:0] s;
    s = b ^ 16'(k * 'h1F35);
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

  function automatic bit m_frozen(input int d, input int k);
    return m_active[d] && (m_n[d] >= (k + 1) * dw[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) m_lfsr[d][k] = m_seed(16'hACE1, k);
      m_active[d] = 1'b0;
      m_n[d]      = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < nr[d]; k++) begin
        if (seed_load && !m_active[d]) m_lfsr[d][k] = m_seed(seed_val, k);
        else if (!m_frozen(d, k))      m_lfsr[d][k] = m_galois(m_lfsr[d][k]);
      end
      if (stop_req) begin
        if (!m_active[d]) begin
          m_active[d] = 1'b1;
          m_n[d]      = 0;
        end else if (m_n[d] <= nr[d] * dw[d]) begin
          m_n[d]++;
        end
      end else begin
        m_active[d] = 1'b0;
        m_n[d]      = 0;
      end
    end
  endtask

  task automatic do_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_rn, e_fr, e_pu;
    logic [31:0] o_rn, o_fr, o_pu;
    logic        e_dn, e_bs, o_dn, o_bs;
    for (int d = 0; d < 2; d++) begin
      e_rn = '0;
      e_fr = '0;
      e_pu = '0;
      for (int k = 0; k < nr[d]; k++) begin
        e_rn = e_rn | (32'(m_lfsr[d][k] & 16'((1 << nw[d]) - 1)) << (k * nw[d]));
        e_fr[k] = m_frozen(d, k);
        e_pu[k] = m_active[d] && (m_n[d] == (k + 1) * dw[d]);
      end
      e_dn = m_active[d] && (m_n[d] >= nr[d] * dw[d]);
      e_bs = m_active[d] && (m_n[d] <  nr[d] * dw[d]);
      o_rn = (d == 0) ? 32'(rn0) : 32'(rn1);
      o_fr = (d == 0) ? 32'(fr0) : 32'(fr1);
      o_pu = (d == 0) ? 32'(pu0) : 32'(pu1);
      o_dn = (d == 0) ? dn0 : dn1;
      o_bs = (d == 0) ? bs0 : bs1;
      do_check($sformatf("dut%0d rand_nums", d), o_rn, e_rn);
      do_check($sformatf("dut%0d frozen", d), o_fr, e_fr);
      do_check($sformatf("dut%0d reel_stop_pulse", d), o_pu, e_pu);
      do_check($sformatf("dut%0d done", d), 32'(o_dn), 32'(e_dn));
      do_check($sformatf("dut%0d busy", d), 32'(o_bs), 32'(e_bs));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n, input logic s);
    stop_req = s;
    repeat (n) step();
  endtask

  initial begin
    reset     = 1'b0;
    stop_req  = 1'b0;
    seed_load = 1'b0;
    seed_val  = 16'h0000;
    model_reset();
    #1 reset = 1'b1;
    #1 check_all();
    repeat (2) step();
    @(negedge clk) reset = 1'b0;

    // Free spin, then a full hold through DONE and beyond.
    run(20, 1'b0);
    run(150, 1'b1);

    // Abort mid-sequence, then re-raise.
    run(3, 1'b0);
    run(26, 1'b1);
    run(4, 1'b0);
    run(15, 1'b1);

    // Asynchronous reset between edges while spinning, then a fresh sequence.
    run(3, 1'b0);
    run(18, 1'b1);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    step();
    @(negedge clk) reset = 1'b0;
    run(45, 1'b1);

    // Abort landing exactly on a dwell-terminal edge of the default instance.
    run(2, 1'b0);
    run(10, 1'b1);
    run(3, 1'b0);

`ifdef REEL_SEED_LOAD_EN
    run(2, 1'b0);
    seed_load = 1'b1;
    seed_val  = 16'h1234;
    step();
    seed_load = 1'b0;
    run(3, 1'b0);
    run(3, 1'b1);
    seed_load = 1'b1;
    seed_val  = 16'hBEEF;
    step();
    seed_load = 1'b0;
    run(5, 1'b1);
    run(2, 1'b0);
    seed_load = 1'b1;
    seed_val  = 16'h1F35;
    step();
    seed_load = 1'b0;
    run(3, 1'b0);
`endif

    // Random stop_req runs.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) stop_req = ~stop_req;
`ifdef REEL_SEED_LOAD_EN
      seed_load = ($urandom_range(0, 7) == 0);
      seed_val  = 16'($urandom);
`endif
      step();
    end
    seed_load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
